// File: rtl/vga_timing_param.sv
// Parametrised VGA timing generator: integer clock divider feeding h/v counters,
// with registered sync, data-enable, active coordinates and line/frame strobes.
module vga_timing_param #(
    parameter int clk_freq   = 50000000,
    parameter int pixel_freq = 25000000,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_POL      = 1'b0,
    parameter bit V_POL      = 1'b0,
    parameter int H_WIDTH    = 10,
    parameter int V_WIDTH    = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               h_sync,
    output logic               v_sync,
    output logic [H_WIDTH-1:0] h_pixel,
    output logic [V_WIDTH-1:0] v_pixel,
    output logic               de,
    output logic               pixel_tick,
    output logic               line_start,
    output logic               frame_start
);
    localparam int DIV     = clk_freq / pixel_freq;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0]  DIV_ONE  = DW'(1);
    localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_ONE    = HCW'(1);
    localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_ONE    = VCW'(1);

    if (DIV < 1 || (clk_freq % pixel_freq) != 0) begin : g_bad_div
        $error("clk_freq must be a positive integer multiple of pixel_freq");
    end
    if ((H_ACTIVE - 1) >= (1 << H_WIDTH) || (V_ACTIVE - 1) >= (1 << V_WIDTH)) begin : g_bad_width
        $error("H_WIDTH/V_WIDTH too narrow for the active area");
    end

    logic [DW-1:0]      div_q, div_d;
    logic [HCW-1:0]     h_cnt_q, h_cnt_d;
    logic [VCW-1:0]     v_cnt_q, v_cnt_d;
    logic               h_sync_q, h_sync_d;
    logic               v_sync_q, v_sync_d;
    logic [H_WIDTH-1:0] h_pixel_q, h_pixel_d;
    logic [V_WIDTH-1:0] v_pixel_q, v_pixel_d;
    logic               de_q, de_d;
    logic               pixel_tick_q, pixel_tick_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic               tick;
    logic               in_active;

    assign tick      = enable && (div_q == DIV_LAST);
    assign in_active = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);

    always_comb begin
        // NOTE: every always_comb target is given a default first so no path can infer a latch.
        div_d         = div_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        h_pixel_d     = h_pixel_q;
        v_pixel_d     = v_pixel_q;
        de_d          = de_q;
        pixel_tick_d  = tick;
        line_start_d  = tick && (h_cnt_q == '0);
        frame_start_d = tick && (h_cnt_q == '0) && (v_cnt_q == '0);

        if (!enable) begin
            // Dropping enable behaves like reset: counters cleared, outputs idle.
            div_d     = '0;
            h_cnt_d   = '0;
            v_cnt_d   = '0;
            h_sync_d  = ~H_POL;
            v_sync_d  = ~V_POL;
            h_pixel_d = '0;
            v_pixel_d = '0;
            de_d      = 1'b0;
        end else if (tick) begin
            // Outputs describe the pixel being left; counters then advance.
            de_d      = in_active;
            h_sync_d  = (int'(h_cnt_q) >= H_ACTIVE + H_FP &&
                         int'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC) ? H_POL : ~H_POL;
            v_sync_d  = (int'(v_cnt_q) >= V_ACTIVE + V_FP &&
                         int'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC) ? V_POL : ~V_POL;
            h_pixel_d = in_active ? H_WIDTH'(h_cnt_q) : '0;
            v_pixel_d = in_active ? V_WIDTH'(v_cnt_q) : '0;
            div_d     = '0;
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + V_ONE;
            end else begin
                h_cnt_d = h_cnt_q + H_ONE;
            end
        end else begin
            div_d = div_q + DIV_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            h_sync_q      <= ~H_POL;
            v_sync_q      <= ~V_POL;
            h_pixel_q     <= '0;
            v_pixel_q     <= '0;
            de_q          <= 1'b0;
            pixel_tick_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            h_pixel_q     <= h_pixel_d;
            v_pixel_q     <= v_pixel_d;
            de_q          <= de_d;
            pixel_tick_q  <= pixel_tick_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign h_pixel     = h_pixel_q;
    assign v_pixel     = v_pixel_q;
    assign de          = de_q;
    assign pixel_tick  = pixel_tick_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param: three configurations driven from one clock, with a
// closed-form per-edge reference model feeding a scoreboard plus targeted measurements.
module tb_vga_timing_param;
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       pt;
        logic       ls;
        logic       fs;
        logic [9:0] hp;
        logic [8:0] vp;
    } vga_t;

    typedef struct packed {
        int div;
        int ha; int hf; int hsw; int hb;
        int va; int vf; int vsw; int vb;
        bit hpol; bit vpol;
    } cfg_t;

    localparam cfg_t CFG_A = '{div:2, ha:640, hf:16, hsw:96, hb:48,
                               va:480, vf:10, vsw:2, vb:33, hpol:1'b0, vpol:1'b0};
    localparam cfg_t CFG_B = '{div:2, ha:16, hf:2, hsw:4, hb:2,
                               va:10, vf:2, vsw:2, vb:2, hpol:1'b0, vpol:1'b0};
    localparam cfg_t CFG_C = '{div:1, ha:8, hf:1, hsw:2, hb:1,
                               va:4, vf:1, vsw:1, vb:1, hpol:1'b1, vpol:1'b1};

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    logic en_a, en_b, en_c;

    logic       a_hs, a_vs, a_de, a_pt, a_ls, a_fs;
    logic [9:0] a_hp;
    logic [8:0] a_vp;
    logic       b_hs, b_vs, b_de, b_pt, b_ls, b_fs;
    logic [4:0] b_hp;
    logic [3:0] b_vp;
    logic       c_hs, c_vs, c_de, c_pt, c_ls, c_fs;
    logic [2:0] c_hp;
    logic [1:0] c_vp;

    vga_t obs_a, obs_b, obs_c;
    assign obs_a = {a_hs, a_vs, a_de, a_pt, a_ls, a_fs, a_hp, a_vp};
    assign obs_b = {b_hs, b_vs, b_de, b_pt, b_ls, b_fs, 5'd0, b_hp, 5'd0, b_vp};
    assign obs_c = {c_hs, c_vs, c_de, c_pt, c_ls, c_fs, 7'd0, c_hp, 7'd0, c_vp};

    always #5 clk = ~clk;

    vga_timing_param u_dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a),
        .h_sync(a_hs), .v_sync(a_vs), .h_pixel(a_hp), .v_pixel(a_vp), .de(a_de),
        .pixel_tick(a_pt), .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_param #(
        .clk_freq(50000000), .pixel_freq(25000000),
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .H_POL(1'b0), .V_POL(1'b0), .H_WIDTH(5), .V_WIDTH(4)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b),
        .h_sync(b_hs), .v_sync(b_vs), .h_pixel(b_hp), .v_pixel(b_vp), .de(b_de),
        .pixel_tick(b_pt), .line_start(b_ls), .frame_start(b_fs)
    );

    vga_timing_param #(
        .clk_freq(25000000), .pixel_freq(25000000),
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .H_WIDTH(3), .V_WIDTH(2)
    ) u_dut_c (
        .clk(clk), .reset(rst_c), .enable(en_c),
        .h_sync(c_hs), .v_sync(c_vs), .h_pixel(c_hp), .v_pixel(c_vp), .de(c_de),
        .pixel_tick(c_pt), .line_start(c_ls), .frame_start(c_fs)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected outputs after the n-th enabled edge since reset release / enable rise.
    function automatic vga_t expect_out(int n, cfg_t c);
        vga_t o;
        int htot, vtot, k, p, h, v;
        bit first;
        htot = c.ha + c.hf + c.hsw + c.hb;
        vtot = c.va + c.vf + c.vsw + c.vb;
        o    = '0;
        o.hs = ~c.hpol;
        o.vs = ~c.vpol;
        if (n < c.div) return o;
        k     = n - c.div;
        p     = k / c.div;
        first = (k % c.div) == 0;
        h     = p % htot;
        v     = (p / htot) % vtot;
        o.de  = (h < c.ha) && (v < c.va);
        o.hs  = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsw) ? c.hpol : ~c.hpol;
        o.vs  = (v >= c.va + c.vf && v < c.va + c.vf + c.vsw) ? c.vpol : ~c.vpol;
        o.hp  = o.de ? 10'(h) : 10'd0;
        o.vp  = o.de ? 9'(v) : 9'd0;
        o.pt  = first;
        o.ls  = first && (h == 0);
        o.fs  = first && (h == 0) && (v == 0);
        return o;
    endfunction

    function automatic int nxt(int n, logic r, logic e);
        return (!r || !e) ? 0 : n + 1;
    endfunction

    function automatic vga_t get_obs(int which);
        case (which)
            0:       return obs_a;
            1:       return obs_b;
            default: return obs_c;
        endcase
    endfunction

    // Scoreboard: expectation pushed at each edge, compared on the following falling edge.
    int   n_a = 0, n_b = 0, n_c = 0;
    vga_t q_a[$], q_b[$], q_c[$];

    always @(posedge clk) begin
        q_a.push_back(expect_out(nxt(n_a, rst_a, en_a), CFG_A));
        q_b.push_back(expect_out(nxt(n_b, rst_b, en_b), CFG_B));
        q_c.push_back(expect_out(nxt(n_c, rst_c, en_c), CFG_C));
        n_a <= nxt(n_a, rst_a, en_a);
        n_b <= nxt(n_b, rst_b, en_b);
        n_c <= nxt(n_c, rst_c, en_c);
    end

    always @(negedge clk) begin
        if (q_a.size() > 0) check("scb_a", 32'(obs_a), 32'(q_a.pop_front()));
        if (q_b.size() > 0) check("scb_b", 32'(obs_b), 32'(q_b.pop_front()));
        if (q_c.size() > 0) check("scb_c", 32'(obs_c), 32'(q_c.pop_front()));
    end

    task automatic edges_until(input int which, input bit want_fs, input int limit, output int edges);
        vga_t o;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            o = get_obs(which);
        end while (!(want_fs ? o.fs : o.ls) && edges < limit);
    endtask

    initial begin
        int   e;
        int   first_hs, hs_cnt, hs_de, max_hp, hp_after;
        int   vs_cnt, vs_tog, vs_bad, first_vs, extra_fs, pt_low;
        vga_t o, prev;
        vga_t idle_a, idle_b, idle_c;

        idle_a = expect_out(0, CFG_A);
        idle_b = expect_out(0, CFG_B);
        idle_c = expect_out(0, CFG_C);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        en_a  = 1'b1; en_b  = 1'b1; en_c  = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_a", 32'(obs_a), 32'(idle_a));
        check("reset_b", 32'(obs_b), 32'(idle_b));
        check("reset_c", 32'(obs_c), 32'(idle_c));

        // Default timing: first pixel, line period, horizontal sync window.
        @(negedge clk); rst_a = 1'b1;
        edges_until(0, 1'b1, 10, e);
        check("a_first_fs_edge", 32'(e), 32'd2);
        check("a_first_px", 32'({a_de, a_pt, a_ls, a_fs, a_hp, a_vp}), 32'({4'b1111, 19'd0}));
        edges_until(0, 1'b0, 4000, e);
        check("a_line_period", 32'(e), 32'd1600);

        first_hs = -1; hs_cnt = 0; hs_de = 0; max_hp = 0; hp_after = -1;
        for (int i = 0; i < 1600; i++) begin
            if (i != 0) begin @(posedge clk); #1; end
            o = obs_a;
            if (!o.hs) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = i;
                if (o.de) hs_de++;
            end
            if (int'(o.hp) > max_hp) max_hp = int'(o.hp);
            if (i == 1280) hp_after = int'(o.hp);
        end
        check("a_hs_start", 32'(first_hs), 32'd1312);
        check("a_hs_width", 32'(hs_cnt), 32'd192);
        check("a_hs_de_overlap", 32'(hs_de), 32'd0);
        check("a_hp_max", 32'(max_hp), 32'd639);
        check("a_hp_at_640", 32'(hp_after), 32'd0);
        edges_until(0, 1'b0, 4000, e);
        check("a_line_period2", 32'(e), 32'd1);

        // Drop enable in the middle of a sync pulse, hold ~100 clks, re-enable.
        e = 0;
        while (a_hs !== 1'b0 && e < 2000) begin @(posedge clk); #1; e++; end
        check("a_hs_reached", 32'(e < 2000), 32'd1);
        @(negedge clk); en_a = 1'b0;
        @(posedge clk); #1;
        check("a_idle_after_drop", 32'(obs_a), 32'(idle_a));
        repeat (100) @(negedge clk);
        en_a = 1'b1;
        edges_until(0, 1'b1, 10, e);
        check("a_reenable_fs_edge", 32'(e), 32'd2);
        check("a_reenable_px", 32'({a_de, a_pt, a_ls, a_fs, a_hp, a_vp}), 32'({4'b1111, 19'd0}));

        // Small DIV=2 frame: frame period and vertical sync.
        @(negedge clk); rst_b = 1'b1;
        edges_until(1, 1'b1, 10, e);
        check("b_first_fs_edge", 32'(e), 32'd2);
        vs_cnt = 0; vs_tog = 0; vs_bad = 0; first_vs = -1; extra_fs = 0;
        prev = obs_b;
        for (int i = 0; i < 768; i++) begin
            if (i != 0) begin @(posedge clk); #1; end
            o = obs_b;
            if (!o.vs) begin
                vs_cnt++;
                if (first_vs < 0) first_vs = i;
            end
            if (i != 0 && o.vs != prev.vs) begin
                vs_tog++;
                if (!o.ls) vs_bad++;
            end
            if (i != 0 && o.fs) extra_fs++;
            prev = o;
        end
        @(posedge clk); #1;
        check("b_frame_period", 32'(b_fs), 32'd1);
        check("b_vs_width", 32'(vs_cnt), 32'd96);
        check("b_vs_start", 32'(first_vs), 32'd576);
        check("b_vs_toggles", 32'(vs_tog), 32'd2);
        check("b_vs_not_on_ls", 32'(vs_bad), 32'd0);
        check("b_extra_fs", 32'(extra_fs), 32'd0);

        // Asynchronous reset mid-frame, checked before any clock edge.
        repeat (200) @(negedge clk);
        #2 rst_b = 1'b0;
        #1 check("b_async_idle", 32'(obs_b), 32'(idle_b));
        @(negedge clk); rst_b = 1'b1;
        edges_until(1, 1'b1, 10, e);
        check("b_post_reset_fs_edge", 32'(e), 32'd2);

        // DIV=1, positive sync polarity.
        @(negedge clk); rst_c = 1'b1;
        edges_until(2, 1'b1, 10, e);
        check("c_first_fs_edge", 32'(e), 32'd1);
        pt_low = 0; hs_cnt = 0; first_hs = -1; extra_fs = 0;
        for (int i = 0; i < 84; i++) begin
            if (i != 0) begin @(posedge clk); #1; end
            o = obs_c;
            if (!o.pt) pt_low++;
            if (i < 12 && o.hs) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = i;
            end
            if (i != 0 && o.fs) extra_fs++;
        end
        @(posedge clk); #1;
        check("c_frame_period", 32'(c_fs), 32'd1);
        check("c_pixel_tick_low", 32'(pt_low), 32'd0);
        check("c_hs_width", 32'(hs_cnt), 32'd2);
        check("c_hs_start", 32'(first_hs), 32'd9);
        check("c_extra_fs", 32'(extra_fs), 32'd0);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
